// File: rtl/micro_pipe_chain_if.sv
// Handshake bundle between the control-store side, the pipeline and the execute stage.
// Carries stall_count only when MICRO_PIPE_STALL_CNT_EN is defined.
interface micro_pipe_chain_if #(
    parameter int ALU_W  = 4,
    parameter int SH_W   = 2,
    parameter int C_W    = 6,
    parameter int T_W    = 7,
    parameter int STAGES = 2
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic             in_valid;
    logic             in_ready;
    logic [ALU_W-1:0] in_alu;
    logic [SH_W-1:0]  in_sh;
    logic [C_W-1:0]   in_c;
    logic [T_W-1:0]   in_t;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ALU_W-1:0] out_alu;
    logic [SH_W-1:0]  out_sh;
    logic [C_W-1:0]   out_c;
    logic [T_W-1:0]   out_t;
    logic [CNT_W-1:0] occupancy;
`ifdef MICRO_PIPE_STALL_CNT_EN
    logic [15:0]      stall_count;

    modport slave (
        input  in_valid, in_alu, in_sh, in_c, in_t, flush, out_ready,
        output in_ready, out_valid, out_alu, out_sh, out_c, out_t, occupancy, stall_count
    );
    modport master (
        output in_valid, in_alu, in_sh, in_c, in_t, flush, out_ready,
        input  in_ready, out_valid, out_alu, out_sh, out_c, out_t, occupancy, stall_count
    );
`else
    modport slave (
        input  in_valid, in_alu, in_sh, in_c, in_t, flush, out_ready,
        output in_ready, out_valid, out_alu, out_sh, out_c, out_t, occupancy
    );
    modport master (
        output in_valid, in_alu, in_sh, in_c, in_t, flush, out_ready,
        input  in_ready, out_valid, out_alu, out_sh, out_c, out_t, occupancy
    );
`endif
endinterface

// File: rtl/micro_pipe_chain.sv
// Elastic microinstruction pipeline with bubble squeezing, flush and occupancy count.
// Optional saturating stall counter enabled by MICRO_PIPE_STALL_CNT_EN.
module micro_pipe_chain #(
    parameter int ALU_W  = 4,
    parameter int SH_W   = 2,
    parameter int C_W    = 6,
    parameter int T_W    = 7,
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    micro_pipe_chain_if.slave bus
);
    localparam int CNT_W = $clog2(STAGES + 1);
    localparam int PW    = ALU_W + SH_W + C_W + T_W;

    logic [STAGES-1:0] v_reg;
    logic [PW-1:0]     p_reg [STAGES];
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_v;
    logic [PW-1:0]     src_p [STAGES];
    logic [CNT_W-1:0]  occ_reg;
    logic [CNT_W-1:0]  occ_next;
    logic              in_ready;
    logic              out_valid;
    logic              in_xfer;
    logic              out_xfer;

    // A stage can take new data if it is empty or the stage below it is moving.
    always_comb begin
        rdy = '0;
        rdy[STAGES-1] = bus.out_ready | ~v_reg[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            rdy[k] = rdy[k+1] | ~v_reg[k];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign src_v[gi] = bus.in_valid;
                assign src_p[gi] = {bus.in_alu, bus.in_sh, bus.in_c, bus.in_t};
            end else begin : g_body
                assign src_v[gi] = v_reg[gi-1];
                assign src_p[gi] = p_reg[gi-1];
            end
        end
    endgenerate

    assign in_ready  = rdy[0] & ~bus.flush;
    assign out_valid = v_reg[STAGES-1] & ~bus.flush;
    assign in_xfer   = bus.in_valid & in_ready;
    assign out_xfer  = out_valid & bus.out_ready;

    always_comb begin
        occ_next = occ_reg;
        if (in_xfer && !out_xfer) begin
            occ_next = occ_reg + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_next = occ_reg - CNT_W'(1);
        end
    end

    // Payload only reloads from a valid source so emptied stages keep stale data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_reg   <= '0;
            occ_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                p_reg[k] <= '0;
            end
        end else if (bus.flush) begin
            v_reg   <= '0;
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_reg[k] <= src_v[k];
                    if (src_v[k]) begin
                        p_reg[k] <= src_p[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.occupancy = occ_reg;
    assign {bus.out_alu, bus.out_sh, bus.out_c, bus.out_t} = p_reg[STAGES-1];

`ifdef MICRO_PIPE_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_reg <= '0;
        end else if (out_valid && !bus.out_ready && stall_reg != 16'hFFFF) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign bus.stall_count = stall_reg;
`endif

endmodule

// File: doc/micro_pipe_chain.md
Name: micro_pipe_chain

Overview:
- Parametrised, elastic microinstruction pipeline. Carries the ALU/SH/C/T control fields across STAGES registered stages.
- Adds per-stage valid bits, valid/ready backpressure with bubble squeezing, synchronous flush, and an occupancy count.
- Sits between the microsequencer's control-store output and the datapath execute stage.
- Replaces fixed, pass-through stage registers.

Parameters:
- ALU_W, 4, width of ALU function field
- SH_W, 2, width of shifter control field
- C_W, 6, width of C (destination/bus) field
- T_W, 7, width of T (target/sequencing) field
- STAGES, 2, number of register stages; legal range 1..16
- CNT_W, $clog2(STAGES+1), occupancy counter width (derived)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream microinstruction present
- in_ready  out  1  stage 0 can accept this cycle
- in_alu  in  ALU_W  ALU field
- in_sh  in  SH_W  shifter field
- in_c  in  C_W  C field
- in_t  in  T_W  T field
- flush  in  1  synchronous pipeline clear
- out_valid  out  1  last stage holds a microinstruction
- out_ready  in  1  datapath consumes this cycle
- out_alu  out  ALU_W  ALU field from last stage
- out_sh  out  SH_W  shifter field from last stage
- out_c  out  C_W  C field from last stage
- out_t  out  T_W  T field from last stage
- occupancy  out  CNT_W  number of valid stages

Behaviour:
- Reset: clock and reset as already decided — one clock; reset is asynchronous and active-low.
  - reset_n=0 immediately clears all valid bits, all payload registers and occupancy to 0.
  - Hence out_valid=0, out_* fields=0, occupancy=0.
  - Release is synchronous to clock.
- Stage storage: stage k has v[k] and payload p[k] = {alu, sh, c, t}. Stage 0 is fed by in_*. Stage STAGES-1 drives out_* directly from registers; there is no combinational input-to-output path.
- Ready chain (combinational):
  - rdy[STAGES-1] = out_ready | ~v[STAGES-1]
  - rdy[k] = rdy[k+1] | ~v[k]
  - in_ready = rdy[0] & ~flush
- Advance on each rising edge when flush=0:
  - If rdy[k]: v[k] <= source valid, where source is v[k-1], or in_valid for k=0.
  - p[k] loads the source payload only when the source is valid; otherwise p[k] holds.
  - If ~rdy[k]: stage k holds.
- Bubble squeezing: an empty stage accepts from upstream even when downstream is stalled.
- Latency: STAGES cycles from in_valid&in_ready to out_valid, with no backpressure. Throughput is 1 per cycle.
- Output stability: while out_valid=1 and out_ready=0, out_* and out_valid hold unchanged.
- Flush:
  - flush=1 forces in_ready=0 and out_valid=0 that cycle, so no transfer occurs on either side.
  - Next edge clears every v[k]; payloads hold.
  - Flush has priority over all movement.
- Occupancy:
  - Registered count of set v bits.
  - Updates +1 on input transfer, −1 on output transfer, unchanged when both or neither occur.
  - Goes to 0 on flush.
  - Never exceeds STAGES.
- Full: occupancy=STAGES and out_ready=0 gives in_ready=0.
- Empty: out_valid=0, and in_ready=1 unless flush.
- STAGES=1: a single skid-less register; in_ready = out_ready | ~v[0].
- out_* contents while out_valid=0: don't-care, except 0 after reset.

Optional Feature:
- Macro: MICRO_PIPE_STALL_CNT_EN
- Defined:
  - Adds output port stall_count (16 bits).
  - Increments each cycle with out_valid=1 and out_ready=0; saturates at 0xFFFF.
  - Cleared only by reset_n. Flush does not clear it, and flush cycles do not count because out_valid=0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert reset_n=0 mid-stream with occupancy=2 → out_valid=0, out_*=0, occupancy=0 with no clock edge; in_ready=1 after release.
- Streaming: STAGES=2, out_ready=1, inject ALU=0x3,SH=2,C=0x15,T=0x41 then ALU=0xA,SH=1,C=0x2A,T=0x7F back-to-back → emerge 2 cycles later on consecutive cycles, in order; occupancy=2 steady.
- Backpressure: out_ready=0 with 2 words in flight → in_ready=0, out_* frozen at the first word. Raise out_ready → one word per cycle, none lost or duplicated.
- Bubble squeeze: STAGES=3, out_ready=0, one word at the output and stages 0–1 empty → in_ready=1. Two more words accepted; the fourth is refused (in_ready=0, occupancy=3).
- Flush: occupancy=2, flush=1 with in_valid=1 → out_valid=0 and in_ready=0 that cycle; next cycle occupancy=0, out_valid=0, and the input word is dropped.
- Stall counter (macro on): hold out_valid=1,out_ready=0 for 5 cycles → stall_count=5; force 70000 stalled cycles → stall_count=0xFFFF.
